// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, issues one big-endian word read per request, loads IR.
// Optional macro IFU_ALIGN_CHECK_EN traps misaligned fetches into a sticky ERR state.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic        halt,
  input  logic        pc_wre,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [25:0] jaddr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] IDataOut,
  output logic [31:0] IAddr,
  output logic        RW,
  output logic [31:0] IR,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DONE = 2'd2
`ifdef IFU_ALIGN_CHECK_EN
    , ERR = 2'd3
`endif
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, pc_next;
  logic        pc_upd, fetch_go, last_addr;
  logic        unused_imm;

  // Branch offset is in words, so the top two bits fall off the shift.
  assign unused_imm = ^imm[31:30];

  assign pc_plus4  = pc_q + 32'd4;
  assign pc        = pc_q;
  assign IAddr     = pc_q;
  assign IR        = ir_q;
  assign last_addr = (state_q == ADDR) && (wait_q == WAIT_LAST);
  assign fetch_go  = (state_q == IDLE) && fetch_req && !halt;
  assign pc_upd    = pc_wre && !halt && ((state_q == IDLE) || (state_q == DONE));
  assign pc_d      = pc_upd ? pc_next : pc_q;

  always_comb begin
    pc_next = pc_plus4;
    case (pc_src)
      2'b00:   pc_next = pc_plus4;
      2'b01:   pc_next = pc_plus4 + {imm[29:0], 2'b00};
      2'b10:   pc_next = {pc_plus4[31:28], jaddr, 2'b00};
      default: pc_next = jr_addr;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fetch issued together with pc_wre uses the updated PC, so alignment is judged on pc_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_go) begin
`ifdef IFU_ALIGN_CHECK_EN
          state_d = (pc_d[1:0] != 2'b00) ? ERR : ADDR;
`else
          state_d = ADDR;
`endif
        end
      end
      ADDR: begin
        if (wait_q == WAIT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    RW       = 1'b0;
    ir_valid = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE:    busy     = 1'b0;
      ADDR:    RW       = 1'b1;
      DONE:    ir_valid = 1'b1;
      default: busy     = 1'b1;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign fetch_err = (state_q == ERR);
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    wait_d = wait_q;
    ir_d   = ir_q;
    if (state_q == ADDR) wait_d = wait_q + 3'd1;
    if (fetch_go)        wait_d = 3'd0;
    if (last_addr)       ir_d   = IDataOut;
`ifdef IFU_ALIGN_CHECK_EN
    if (state_d == ERR)  ir_d   = 32'd0;
`endif
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= RESET_PC;
      ir_q   <= 32'd0;
      wait_q <= 3'd0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the multi-cycle CPU: the requesting end of the byte-addressed, big-endian instruction memory read port. It owns the PC, drives the memory address and read enable, captures the 32-bit word into the instruction register and reports completion to the control unit. It also computes the next PC for sequential, branch, jump and register-jump flow.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- WAIT_CYCLES, 0, extra memory latency cycles inserted before IR capture; legal range 0–7.

Ports:
- CLK  in  1  clock; all registers update on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  request one instruction fetch; sampled only in IDLE.
- halt  in  1  freezes fetching and PC updates.
- pc_wre  in  1  commit the next PC at this edge.
- pc_src  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register jump.
- imm  in  32  sign-extended branch offset, in words.
- jaddr  in  26  jump target field.
- jr_addr  in  32  register-jump target.
- IDataOut  in  32  memory read data; high-Z when RW=0.
- IAddr  out  32  memory byte address; always equals pc.
- RW  out  1  memory read enable; high only in ADDR.
- IR  out  32  instruction register.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational.
- ir_valid  out  1  one-cycle pulse when IR holds a freshly fetched word.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  sticky misalignment flag; see Configuration.

## Operation
- FSM states and transitions:
  - IDLE → ADDR when fetch_req=1 and halt=0.
  - ADDR → DONE after WAIT_CYCLES+1 cycles. A 3-bit wait counter clears on entry to ADDR.
  - DONE → IDLE unconditionally.
  - ERR exists only with the macro (see Configuration).
- ADDR: RW=1 and IAddr=pc. On the final ADDR edge, IR ← IDataOut. IDataOut[31:24] is the byte at pc and IDataOut[7:0] is the byte at pc+3.
- DONE: ir_valid=1. IR holds its value until the next capture.
- fetch_req outside IDLE is ignored and not queued.
- Next PC, all arithmetic modulo 2^32:
  - 00: pc+4.
  - 01: pc+4 + (imm<<2); imm[31:30] are discarded.
  - 10: {pc_plus4[31:28], jaddr, 2'b00}.
  - 11: jr_addr.
- pc_wre:
  - Honored in IDLE and DONE.
  - Ignored in ADDR, so the address stays stable for the whole fetch.
  - Ignored whenever halt=1.
- pc_wre and fetch_req in the same IDLE cycle: the PC updates at that edge and the fetch uses the updated PC.
- halt asserted during ADDR: the fetch in progress completes normally. No new fetch starts until halt=0.
- Reset values: state IDLE, pc=RESET_PC, IR=0, ir_valid=0, RW=0, busy=0, wait counter 0, fetch_err=0.
- Reset asserted mid-fetch aborts immediately: RW drops to 0 asynchronously, IR=0, and no ir_valid is produced.

## Timing
- fetch_req sampled high at edge k (IDLE) → ADDR during cycles k+1 … k+1+WAIT_CYCLES.
- IR captured at the edge ending cycle k+1+WAIT_CYCLES.
- ir_valid high during cycle k+2+WAIT_CYCLES. busy low again from cycle k+3+WAIT_CYCLES.
- Minimum fetch-to-fetch spacing is WAIT_CYCLES+3 cycles.
- The pc / pc_plus4 change is visible the cycle after the pc_wre edge.

## Configuration
- IFU_ALIGN_CHECK_EN defined:
  - A fetch_req accepted in IDLE with pc[1:0]≠0 goes to ERR instead of ADDR. RW stays 0 and no memory access occurs.
  - In ERR: fetch_err=1, busy=1, IR=0, no ir_valid, pc_wre ignored.
  - ERR is left only by Reset.
- IFU_ALIGN_CHECK_EN undefined:
  - fetch_err is tied to 0 and there is no ERR state.
  - A misaligned PC is fetched like any other, assembling bytes pc..pc+3 big-endian.

## Test plan
- Basic fetch: reset, memory bytes 0..3 = 12,34,56,78, WAIT_CYCLES=0, pulse fetch_req → RW=1 for exactly one cycle with IAddr=0, IR=32'h12345678, ir_valid pulse two cycles after the request edge, pc=0.
- Sequential and branch: from pc=0x8, apply pc_wre with pc_src=00 → pc=0x0C. Then apply pc_src=01 with imm=32'hFFFF_FFFE → pc=0x0C+4−8=0x08.
- Jump, register jump and wrap:
  - pc=0x1000_0004, pc_src=10, jaddr=26'h000_0010 → pc=0x1000_0040.
  - pc_src=11, jr_addr=0xFFFF_FFFC, then pc_src=00 → pc=0x0000_0000.
- Latency and ignore rules with WAIT_CYCLES=3: RW high for 4 cycles and ir_valid on cycle k+5. A fetch_req and a pc_wre issued during ADDR have no effect, and IAddr stays constant.
- Halt and simultaneity:
  - halt=1 in IDLE with fetch_req and pc_wre → no RW, pc unchanged.
  - halt=0 with fetch_req and pc_wre (pc_src=00, pc=0) in the same cycle → fetch reads address 4.
- Reset and alignment:
  - Reset pulsed during ADDR → RW=0 at once, IR=0, no ir_valid, pc=RESET_PC.
  - With IFU_ALIGN_CHECK_EN defined, jr_addr=0x6 then fetch_req → fetch_err=1, RW never asserted, stays in ERR until Reset.
